// File: rtl/signed_width_conv_if.sv
// Beat-level handshake bundle for signed_width_conv: input stream, output stream.
interface signed_width_conv_if #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/signed_width_conv.sv
// Signed/unsigned sample width converter with saturation and a 2-entry output FIFO.
// Optional saturation event counter under SIGNED_WIDTH_CONV_SATCNT_EN.
module signed_width_conv #(
    parameter int unsigned IN_W  = 10,
    parameter int unsigned OUT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    signed_width_conv_if.slave bus
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
    ,
    output logic [15:0]        sat_count
`endif
);

    logic [OUT_W-1:0] conv_data_c;
    logic             conv_sat_c;

    // Combinational conversion of the presented beat
    generate
        if (OUT_W >= IN_W) begin : g_widen
            if (OUT_W == IN_W) begin : g_equal
                assign conv_data_c = bus.in_data;
            end else begin : g_ext
                logic fill_c;
                assign fill_c      = bus.in_signed & bus.in_data[IN_W-1];
                assign conv_data_c = {{(OUT_W-IN_W){fill_c}}, bus.in_data};
            end
            assign conv_sat_c = 1'b0;
        end else begin : g_narrow
            logic neg_c;
            logic s_hi_c;
            logic s_lo_c;
            logic u_over_c;
            // Signed fits iff bits [IN_W-1:OUT_W-1] are all copies of the sign bit
            assign neg_c    = bus.in_data[IN_W-1];
            assign s_hi_c   = ~neg_c & (|bus.in_data[IN_W-1:OUT_W-1]);
            assign s_lo_c   = neg_c & ~(&bus.in_data[IN_W-1:OUT_W-1]);
            assign u_over_c = |bus.in_data[IN_W-1:OUT_W];

            always_comb begin
                conv_data_c = bus.in_data[OUT_W-1:0];
                conv_sat_c  = 1'b0;
                if (bus.in_signed) begin
                    if (s_hi_c) begin
                        conv_data_c = {1'b0, {(OUT_W-1){1'b1}}};
                        conv_sat_c  = 1'b1;
                    end else if (s_lo_c) begin
                        conv_data_c = {1'b1, {(OUT_W-1){1'b0}}};
                        conv_sat_c  = 1'b1;
                    end
                end else if (u_over_c) begin
                    conv_data_c = {OUT_W{1'b1}};
                    conv_sat_c  = 1'b1;
                end
            end
        end
    endgenerate

    logic [1:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [OUT_W-1:0] ent0_data_q, ent0_data_d;
    logic             ent0_sat_q, ent0_sat_d;
    logic [OUT_W-1:0] ent1_data_q, ent1_data_d;
    logic             ent1_sat_q, ent1_sat_d;
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
    logic [15:0]      sat_count_q, sat_count_d;
`endif

    logic in_ready_c;
    logic push_c;
    logic pop_c;

    assign in_ready_c = in_ready_q & ~rst;
    assign push_c     = bus.in_valid & in_ready_c;
    assign pop_c      = out_valid_q & bus.out_ready;

    // Next-state: entry 0 is always the head, entry 1 shifts into it on a pop
    always_comb begin
        count_d     = count_q;
        ent0_data_d = ent0_data_q;
        ent0_sat_d  = ent0_sat_q;
        ent1_data_d = ent1_data_q;
        ent1_sat_d  = ent1_sat_q;
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
        sat_count_d = sat_count_q;
        if (push_c && conv_sat_c && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = 16'(sat_count_q + 16'd1);
        end
`endif
        case ({push_c, pop_c})
            2'b10: begin
                if (count_q == 2'd0) begin
                    ent0_data_d = conv_data_c;
                    ent0_sat_d  = conv_sat_c;
                end else begin
                    ent1_data_d = conv_data_c;
                    ent1_sat_d  = conv_sat_c;
                end
                count_d = 2'(count_q + 2'd1);
            end
            2'b01: begin
                ent0_data_d = ent1_data_q;
                ent0_sat_d  = ent1_sat_q;
                count_d     = 2'(count_q - 2'd1);
            end
            2'b11: begin
                if (count_q == 2'd2) begin
                    ent0_data_d = ent1_data_q;
                    ent0_sat_d  = ent1_sat_q;
                    ent1_data_d = conv_data_c;
                    ent1_sat_d  = conv_sat_c;
                end else begin
                    ent0_data_d = conv_data_c;
                    ent0_sat_d  = conv_sat_c;
                end
            end
            default: ;
        endcase
        out_valid_d = (count_d != 2'd0);
        in_ready_d  = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ent0_data_q <= '0;
            ent0_sat_q  <= 1'b0;
            ent1_data_q <= '0;
            ent1_sat_q  <= 1'b0;
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
            sat_count_q <= 16'd0;
`endif
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ent0_data_q <= ent0_data_d;
            ent0_sat_q  <= ent0_sat_d;
            ent1_data_q <= ent1_data_d;
            ent1_sat_q  <= ent1_sat_d;
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
            sat_count_q <= sat_count_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = ent0_data_q;
    assign bus.out_sat   = ent0_sat_q;
`ifdef SIGNED_WIDTH_CONV_SATCNT_EN
    assign sat_count = sat_count_q;
`endif

endmodule
